rs232rx: RTL

//   Parametrised RS-232 receiver: 16x oversampled, majority-vote bit sampling,

---
 rtl/rs232rx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rs232rx.sv
// rs232rx: 16x oversampled RS-232 receiver with majority-vote sampling,
// parity/framing/break/overrun detection and a show-ahead output FIFO.
// Ports: clock, reset_n (async, active low), serial_in (RXD, idle high),
//   rd_valid/rd_ready/rd_data/rd_parity_err/rd_frame_err (FIFO head),
//   overrun/break_det (sticky flags), err_clear, fifo_level.
module rs232rx #(
   parameter int FREQUENCY = 25_000_000,
   parameter int BPS       = 57_600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int FIFO_LOG2 = 2
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 serial_in,
   output logic                 rd_valid,
   input  logic                 rd_ready,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_parity_err,
   output logic                 rd_frame_err,
   output logic                 overrun,
   output logic                 break_det,
   input  logic                 err_clear,
   output logic [FIFO_LOG2:0]   fifo_level
);

   localparam int DIVISOR = FREQUENCY / (BPS * 16);
   localparam int DW      = $clog2(DIVISOR);
   localparam int DEPTH   = 1 << FIFO_LOG2;
   localparam int WW      = DATA_BITS + 2;
   localparam logic [DW-1:0]      DIV_LAST = DW'(DIVISOR - 1);
   localparam logic [3:0]         BIT_LAST = 4'(DATA_BITS - 1);
   localparam logic [FIFO_LOG2:0] FULL_LVL = (FIFO_LOG2 + 1)'(DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PAR, STOP, STOP2, BRKW
   } state_t;

   state_t state, next;

   logic sync1, rxs, rxs_q;
   logic fall, tick, bit_end, vote;
   logic [DW-1:0] div_cnt;
   logic [3:0] phase;
   logic [3:0] bit_cnt;
   logic v7, v8;
   logic [DATA_BITS-1:0] shreg;
   logic pbit, exp_pbit;
   logic start_det, shift, par_load, push;
   logic perr, ferr, brk;
   logic [WW-1:0] word, head, last_q;
   logic [WW-1:0] mem [DEPTH];
   logic [FIFO_LOG2-1:0] wptr, rptr;
   logic full, pop, accept;

   // Two-flop synchroniser plus one extra stage for edge detection.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_q <= 1'b1;
      end else begin
         sync1 <= serial_in;
         rxs   <= sync1;
         rxs_q <= rxs;
      end
   end

   assign fall    = rxs_q & ~rxs;
   assign tick    = (div_cnt == DIV_LAST);
   assign bit_end = tick && (phase == 4'd9);
   assign vote    = (v7 & v8) | (v7 & rxs) | (v8 & rxs);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next;
   end

   always_comb begin
      next      = state;
      start_det = 1'b0;
      shift     = 1'b0;
      par_load  = 1'b0;
      push      = 1'b0;
      unique case (state)
         IDLE: if (fall) begin
            next      = START;
            start_det = 1'b1;
         end
         START: if (bit_end) next = vote ? IDLE : DATA;
         DATA: if (bit_end) begin
            shift = 1'b1;
            if (bit_cnt == BIT_LAST)
               next = (PARITY != 0) ? PAR : STOP;
         end
         PAR: if (bit_end) begin
            par_load = 1'b1;
            next     = STOP;
         end
         STOP: if (bit_end) begin
            push = 1'b1;
            if (!vote)               next = BRKW;
            else if (STOP_BITS == 2) next = STOP2;
            else                     next = IDLE;
         end
         STOP2: if (bit_end) next = IDLE;
         BRKW:  if (rxs) next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Tick/phase counters restart on the start edge so phase 8 lands
   // near each bit centre.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         phase   <= '0;
         bit_cnt <= '0;
         v7      <= 1'b1;
         v8      <= 1'b1;
         shreg   <= '0;
         pbit    <= 1'b0;
      end else begin
         if (start_det) begin
            div_cnt <= '0;
            phase   <= '0;
            bit_cnt <= '0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)  phase   <= phase + 4'd1;
            if (shift) bit_cnt <= bit_cnt + 4'd1;
         end
         if (tick && phase == 4'd7) v7 <= rxs;
         if (tick && phase == 4'd8) v8 <= rxs;
         if (shift)    shreg <= {vote, shreg[DATA_BITS-1:1]};
         if (par_load) pbit  <= vote;
      end
   end

   // Odd parity: data plus parity bit carry an odd number of ones.
   assign exp_pbit = (PARITY == 1) ? ~(^shreg) : ^shreg;
   assign perr     = (PARITY != 0) && (pbit != exp_pbit);
   assign ferr     = ~vote;
   assign brk      = push & ~vote & (shreg == '0)
                   & ((PARITY == 0) | ~pbit);
   assign word     = {ferr, perr, shreg};

   assign full     = (fifo_level == FULL_LVL);
   assign rd_valid = (fifo_level != '0);
   assign pop      = rd_valid & rd_ready;
   // When full, wptr==rptr: the read sees the old word before the write.
   assign accept   = push & (~full | pop);
   assign head     = mem[rptr];

   assign {rd_frame_err, rd_parity_err, rd_data} =
      rd_valid ? head : last_q;

   always_ff @(posedge clock) begin
      if (accept) mem[wptr] <= word;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_level <= '0;
         last_q     <= '0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         if (accept) wptr <= wptr + 1'b1;
         if (pop) begin
            rptr   <= rptr + 1'b1;
            last_q <= head;
         end
         unique case ({accept, pop})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (push & ~accept) overrun <= 1'b1;
         else if (err_clear) overrun <= 1'b0;
         if (brk)            break_det <= 1'b1;
         else if (err_clear) break_det <= 1'b0;
      end
   end

endmodule
